// File: rtl/gf64_reduce_pipe.sv
// gf64_reduce_pipe
//
// Two-stage pipelined reduction of a 127-bit carry-less product (degree <= 126)
// into GF(2^64), modulo P(x) = x^64 + x^4 + x^3 + x + 1.
//
// Stage 1 folds the upper 63 coefficients down once, which leaves a 67-bit
// remainder. Stage 2 folds the 3 leftover high bits. The second fold cannot
// overflow because its largest term is x^6.
//
// Optional feature macro: GF64_RED_ACC_EN
//   When defined, the block adds an in_acc_clr port and a 64-bit accumulator.
//   Each result is red ^ acc, or just red when the beat carried in_acc_clr.
//   The result is written back to acc. This gives GHASH-style chaining.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    in_data holds a product
//   in_ready    block accepts the product this cycle
//   in_data     [126:0] carry-less product, bit i = coeff of x^i
//   in_acc_clr  (GF64_RED_ACC_EN only) start a new accumulation with this beat
//   out_valid   out_data is valid
//   out_ready   consumer takes out_data this cycle
//   out_data    [63:0] reduced element, bit i = coeff of x^i
//
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high. A producer holding valid keeps its data stable until the transfer.
// in_ready depends combinationally on out_ready and rst, never on in_valid.
// out_data holds steady while out_valid && !out_ready.

module gf64_reduce_pipe (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [126:0] in_data,
`ifdef GF64_RED_ACC_EN
  input  logic         in_acc_clr,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data
);

  logic        s1_valid;
  logic [66:0] s1_data;
  logic        s2_valid;
  logic [63:0] s2_data;
  logic        s1_adv;
  logic        s2_adv;
  logic [62:0] h;
  logic [66:0] r1;
  logic [2:0]  e;
  logic [63:0] red;
  logic [63:0] s2_next;

`ifdef GF64_RED_ACC_EN
  logic        s1_clr;
  logic [63:0] acc;
`endif

  // Fold 1: x^64 == x^4 + x^3 + x + 1, applied to the whole upper half.
  always_comb begin
    h  = in_data[126:64];
    r1 = {3'b000, in_data[63:0]}
       ^ {4'b0000, h}
       ^ {3'b000, h, 1'b0}
       ^ {1'b0, h, 3'b000}
       ^ {h, 4'b0000};
  end

  // Fold 2: only bits 66..64 can remain set after fold 1.
  always_comb begin
    e   = s1_data[66:64];
    red = s1_data[63:0]
        ^ {61'd0, e}
        ^ {60'd0, e, 1'b0}
        ^ {58'd0, e, 3'b000}
        ^ {57'd0, e, 4'b0000};
  end

`ifdef GF64_RED_ACC_EN
  assign s2_next = red ^ (s1_clr ? 64'd0 : acc);
`else
  assign s2_next = red;
`endif

  // A stage may advance when it is empty or its successor is advancing.
  // Chaining the two terms lets a full pipe still accept while it drains.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  // Beats offered during reset are accepted and then dropped by the reset.
  assign in_ready  = s1_adv || rst;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= 67'd0;
      s2_valid <= 1'b0;
      s2_data  <= 64'd0;
`ifdef GF64_RED_ACC_EN
      s1_clr   <= 1'b0;
      acc      <= 64'd0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= r1;
`ifdef GF64_RED_ACC_EN
          s1_clr  <= in_acc_clr;
`endif
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s2_next;
`ifdef GF64_RED_ACC_EN
          acc     <= s2_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gf64_reduce_pipe.sv
// Self-checking bench for gf64_reduce_pipe.
// The reference reducer clears high coefficients one at a time by XORing
// shifted copies of P(x). Expected results live in exp_q in acceptance order.

module tb_gf64_reduce_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [126:0] in_data;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;

  logic [63:0]  exp_q[$];
  logic [63:0]  acc_m;
  int           n_checks = 0;
  int           n_pass   = 0;

  always #5 clk = ~clk;

  gf64_reduce_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef GF64_RED_ACC_EN
    .in_acc_clr(acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_reduce(input logic [126:0] p);
    logic [127:0] t;
    logic [127:0] poly;
    poly = 128'h1_0000_0000_0000_001B;
    t = {1'b0, p};
    for (int i = 126; i >= 64; i--)
      if (t[i]) t = t ^ (poly << (i - 64));
    return t[63:0];
  endfunction

  task automatic model_accept(input logic [126:0] d, input logic clr);
    logic [63:0] v;
`ifdef GF64_RED_ACC_EN
    v = ref_reduce(d) ^ (clr ? 64'd0 : acc_m);
    acc_m = v;
`else
    v = ref_reduce(d);
    if (clr) v = v;
`endif
    exp_q.push_back(v);
  endtask

  task automatic model_reset();
    exp_q.delete();
    acc_m = 64'd0;
  endtask

  // ---------------- drivers ----------------
  function automatic logic [126:0] rand_prod();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[126:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = rand_prod(); acc_clr = 1'b1; out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== 64'd0) $display("FAIL reset_out_data got=%h exp=0", out_data);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_fold_basic();
    logic [126:0] vec[2];
    logic [63:0]  exp_v[2];
    vec[0] = 127'd1 << 64;  exp_v[0] = 64'h0000_0000_0000_001B;
    vec[1] = 127'd1 << 126; exp_v[1] = 64'hC000_0000_0000_005A;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = vec[k]; acc_clr = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL fold%0d_in_ready got=%b exp=1", k, in_ready);
      else n_pass++;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL fold%0d_early_valid got=%b exp=0", k, out_valid);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v[k])
        $display("FAIL fold%0d_result valid=%b got=%h exp=%h", k, out_valid, out_data, exp_v[k]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    out_ready = 1'b1; acc_clr = 1'b1;
    for (int i = 0; i < 104; i++) begin
      in_valid = (i < 100);
      in_data  = rand_prod();
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, in_ready);
      else n_pass++;
      if (i >= 2 && i <= 101) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL stream_out_valid cyc=%0d got=%b exp=1", i, out_valid);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++;
        if (out_data !== e) $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, out_data, e);
        else n_pass++;
      end
      if (in_valid && in_ready) model_accept(in_data, acc_clr);
      step();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stream_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        exp_ready;
    int          n_in;
    int          n_out;
    prev_stall = 1'b0; prev_data = 64'd0; n_in = 0; n_out = 0;
    acc_clr = 1'b1;
    for (int i = 0; i < 210; i++) begin
      in_valid  = (i < 200);
      in_data   = rand_prod();
      out_ready = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      exp_ready = !(exp_q.size() == 2 && !out_ready);
      n_checks++;
      if (in_ready !== exp_ready) $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_ready);
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          $display("FAIL bp_stall_hold cyc=%0d valid=%b got=%h exp=%h", i, out_valid, out_data, prev_data);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_out++;
        n_checks++;
        if (out_data !== e) $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, out_data, e);
        else n_pass++;
      end
      if (in_valid && in_ready) begin
        model_accept(in_data, acc_clr);
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step();
    end
    n_checks++;
    if (n_in != n_out || exp_q.size() != 0)
      $display("FAIL bp_count in=%0d out=%0d left=%0d", n_in, n_out, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [63:0] e;
    out_ready = 1'b0; acc_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = rand_prod();
      step();
    end
    rst = 1'b1; in_valid = 1'b1; in_data = rand_prod();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0)
      $display("FAIL rstmid_clear valid=%b data=%h exp=0/0", out_valid, out_data);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL rstmid_ghost cyc=%0d got=%b exp=0", i, out_valid);
      else n_pass++;
    end
    step();
    in_valid = 1'b1; in_data = rand_prod();
    @(negedge clk);
    if (in_ready) model_accept(in_data, acc_clr);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_early got=%b exp=0", out_valid);
    else n_pass++;
    step();
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== e)
      $display("FAIL rstmid_after valid=%b got=%h exp=%h", out_valid, out_data, e);
    else n_pass++;
    step();
  endtask

`ifdef GF64_RED_ACC_EN
  task automatic test_accumulate();
    logic [126:0] beat[4];
    logic         clr_v[4];
    logic [63:0]  want[4];
    int           idx_s[2][11];
    logic         rdy_s[2][11];
    int           len_s[2];
    int           n_got;
    for (int k = 0; k < 4; k++) beat[k] = rand_prod();
    clr_v[0] = 1'b1; clr_v[1] = 1'b0; clr_v[2] = 1'b0; clr_v[3] = 1'b1;
    want[0] = ref_reduce(beat[0]);
    want[1] = want[0] ^ ref_reduce(beat[1]);
    want[2] = want[1] ^ ref_reduce(beat[2]);
    want[3] = ref_reduce(beat[3]);
    idx_s[0] = '{0, 1, 2, 3, -1, -1, -1, -1, -1, -1, -1};
    rdy_s[0] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    len_s[0] = 8;
    idx_s[1] = '{0, 1, -1, -1, -1, 2, 3, -1, -1, -1, -1};
    rdy_s[1] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    len_s[1] = 11;
    for (int run = 0; run < 2; run++) begin
      n_got = 0;
      for (int c = 0; c < len_s[run]; c++) begin
        in_valid  = (idx_s[run][c] >= 0);
        in_data   = in_valid ? beat[idx_s[run][c]] : 127'd0;
        acc_clr   = in_valid ? clr_v[idx_s[run][c]] : 1'b0;
        out_ready = rdy_s[run][c];
        @(negedge clk);
        if (in_valid) begin
          n_checks++;
          if (in_ready !== 1'b1) $display("FAIL acc%0d_in_ready cyc=%0d got=%b exp=1", run, c, in_ready);
          else n_pass++;
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (n_got < 4 && out_data === want[n_got]) n_pass++;
          else $display("FAIL acc%0d_out%0d got=%h exp=%h", run, n_got, out_data,
                        (n_got < 4) ? want[n_got] : 64'hx);
          n_got++;
        end
        if (in_valid && in_ready) model_accept(in_data, acc_clr);
        step();
      end
      n_checks++;
      if (n_got != 4) $display("FAIL acc%0d_count got=%0d exp=4", run, n_got);
      else n_pass++;
      exp_q.delete();
    end
    in_valid = 1'b0; acc_clr = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 127'd0; acc_clr = 1'b1; out_ready = 1'b0;
    acc_m = 64'd0;
    test_reset();
    test_fold_basic();
    test_stream();
    test_backpressure();
    test_reset_midflight();
`ifdef GF64_RED_ACC_EN
    test_accumulate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
